cpu: RTL and testbench
======================

CPU -- requirements
Module: cpu

Interface
REQ-001 The block SHALL have no parameters; memory depth is fixed at 256 words and the register file at 32 x 32 bits.
REQ-002 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous and active-low; sampled on the rising edge of clk_i.
REQ-004 The block SHALL have no other ports; state SHALL be observable hierarchically: PC.pc_o (32-bit), Registers.register[0..31] (32-bit each), Instruction_Memory.memory[0..255] (32-bit each, bench-loadable).

Function
REQ-005 Single-cycle RV32 datapath: fetch, decode, execute and register writeback of one instruction per clock.
REQ-006 Fetch: instruction = Instruction_Memory.memory[pc_o[9:2]]; asynchronous, combinational read.
REQ-007 Next PC SHALL be pc_o + 4, modulo 2^32; no branches or jumps; addresses past word 255 alias back to word 0.
REQ-008 R-type (opcode 0110011) SHALL support: and (f7 0000000, f3 111), xor (0000000, 100), sll (0000000, 001), add (0000000, 000), sub (0100000, 000), mul (0000001, 000).
REQ-009 I-type (opcode 0010011) SHALL support: addi (f3 000), srai (f3 101, imm[11:5] 0100000).
REQ-010 I-type immediate SHALL be instr[31:20] sign-extended to 32 bits; srai shift amount SHALL be instr[24:20].
REQ-011 sll shift amount SHALL be rs2[4:0]; srai SHALL be an arithmetic shift (sign-filling).
REQ-012 add/sub/addi SHALL wrap modulo 2^32; mul SHALL write the low 32 bits of the product.
REQ-013 Register file: two combinational read ports (rs1 = instr[19:15], rs2 = instr[24:20]); one write port (rd = instr[11:7]), written at the rising edge.
REQ-014 Writes to x0 SHALL be discarded; x0 SHALL always read 0.
REQ-015 Any other encoding, including all-zero words, SHALL be a NOP: no register write, PC still advances by 4.
REQ-016 A result written at edge N SHALL be visible to the instruction fetched after edge N; no forwarding or hazard logic is needed.

Reset
REQ-017 While rst_i is low at a rising edge: pc_o <= 0 and all 32 registers <= 0; no instruction commits on that edge.
REQ-018 Reset asserted mid-program SHALL abort the in-flight instruction; execution restarts at word 0 on the first edge with rst_i high.
REQ-019 Reset SHALL NOT clear Instruction_Memory.

Structure
REQ-020 Shared package: opcode, funct3 and funct7 constants, and the ALU-operation enum.
REQ-021 Top-level instance names SHALL be PC, Registers and Instruction_Memory.
REQ-022 A combinational ALU sub-module (alu: op, a, b -> result) is the natural split; it may be accompanied by small control and sign-extend blocks.

Verification
REQ-023 Reset, then run addi x1,x0,10 and addi x2,x0,-8 -> x1=10, x2=0xFFFFFFF8; pc_o = 0, 4, 8 on successive edges.
REQ-024 With x1=10, x2=-8, run add x3,x1,x2; sub x4,x1,x2; mul x5,x1,x2 -> x3=2, x4=18, x5=-80.
REQ-025 With x1=10, x2=-8, run and x6,x1,x2; xor x7,x1,x2; sll x8,x1,x1 -> x6=8, x7=0xFFFFFFF2, x8=10240.
REQ-026 Run srai x9,x2,1 with x2=-8, then addi x0,x0,5 -> x9=-4 and x0 remains 0.
REQ-027 Fill the program tail with all-zero words -> registers unchanged and PC keeps advancing by 4; assert rst_i low at one edge mid-run -> next pc_o=0 and all registers 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings, ALU operation set and instruction decoder for the
// single-cycle RV32 subset core.
package cpu_pkg;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_XOR,
    ALU_SLL,
    ALU_SRA,
    ALU_MUL
  } alu_op_e;

  typedef struct packed {
    logic    we;
    logic    use_imm;
    alu_op_e op;
  } ctrl_t;

  // Anything not matched below stays a NOP: no writeback, PC still advances.
  function automatic ctrl_t decode(input logic [31:0] instr);
    ctrl_t c;
    c.we      = 1'b0;
    c.use_imm = 1'b0;
    c.op      = ALU_ADD;
    case (instr[6:0])
      OP_R: begin
        case ({instr[31:25], instr[14:12]})
          {F7_BASE, F3_AND}: begin c.we = 1'b1; c.op = ALU_AND; end
          {F7_BASE, F3_XOR}: begin c.we = 1'b1; c.op = ALU_XOR; end
          {F7_BASE, F3_SLL}: begin c.we = 1'b1; c.op = ALU_SLL; end
          {F7_BASE, F3_ADD}: begin c.we = 1'b1; c.op = ALU_ADD; end
          {F7_ALT,  F3_ADD}: begin c.we = 1'b1; c.op = ALU_SUB; end
          {F7_MUL,  F3_ADD}: begin c.we = 1'b1; c.op = ALU_MUL; end
          default: ;
        endcase
      end
      OP_I: begin
        if (instr[14:12] == F3_ADD) begin
          c.we = 1'b1; c.use_imm = 1'b1; c.op = ALU_ADD;
        end else if (instr[14:12] == F3_SR && instr[31:25] == F7_ALT) begin
          c.we = 1'b1; c.use_imm = 1'b1; c.op = ALU_SRA;
        end
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cpu_if.sv
// Register-file access bundle: two read ports and one write port.
interface cpu_if;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        we;
  logic [4:0]  rd;
  logic [31:0] wd;

  modport master (output rs1_addr, rs2_addr, we, rd, wd,
                  input  rs1_data, rs2_data);
  modport slave  (input  rs1_addr, rs2_addr, we, rd, wd,
                  output rs1_data, rs2_data);
endinterface

// File: rtl/cpu_alu.sv
// Combinational ALU plus the state-holding blocks of the core: program
// counter, register file and instruction memory.
module alu
  import cpu_pkg::*;
(
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);
  // NOTE: assign a default before the case so no path leaves result
  // unassigned, which would infer a latch.
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_XOR: result = a ^ b;
      ALU_SLL: result = a << b[4:0];
      ALU_SRA: result = $unsigned($signed(a) >>> b[4:0]);
      ALU_MUL: result = a * b;
      default: result = '0;
    endcase
  end
endmodule

module pc (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] pc_o
);
  // NOTE: sequential state uses non-blocking assignment so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i) begin
    if (!rst_i) pc_o <= '0;
    else        pc_o <= pc_o + 32'd4;
  end
endmodule

module registers (
  input logic   clk_i,
  input logic   rst_i,
  cpu_if.slave  rf
);
  logic [31:0] register [0:31];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 32; i++) register[i] <= '0;
    end else if (rf.we && rf.rd != 5'd0) begin
      register[rf.rd] <= rf.wd;
    end
  end

  assign rf.rs1_data = (rf.rs1_addr == 5'd0) ? '0 : register[rf.rs1_addr];
  assign rf.rs2_data = (rf.rs2_addr == 5'd0) ? '0 : register[rf.rs2_addr];
endmodule

module instruction_memory (
  input  logic [7:0]  addr,
  output logic [31:0] instr
);
  // NOTE: program storage is deliberately not reset; its contents are
  // loaded from outside and must survive a core reset.
  logic [31:0] memory [0:255];

  assign instr = memory[addr];
endmodule

// File: rtl/cpu.sv
// Single-cycle RV32 subset core: fetch, decode, execute and writeback of
// one instruction per rising edge of clk_i.
module cpu
  import cpu_pkg::*;
(
  input logic clk_i,
  input logic rst_i
);
  logic [31:0] pc_val;
  logic [31:0] instr;
  logic [31:0] imm;
  logic [31:0] alu_b;
  logic [31:0] alu_y;
  ctrl_t       ctrl;
  logic        unused_pc_bits;

  cpu_if rf ();

  pc PC (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .pc_o  (pc_val)
  );

  // Only word-address bits select memory, so fetches alias every 1 KiB.
  instruction_memory Instruction_Memory (
    .addr  (pc_val[9:2]),
    .instr (instr)
  );
  assign unused_pc_bits = ^{pc_val[31:10], pc_val[1:0]};

  registers Registers (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .rf    (rf.slave)
  );

  assign ctrl = decode(instr);
  assign imm  = {{20{instr[31]}}, instr[31:20]};

  assign rf.rs1_addr = instr[19:15];
  assign rf.rs2_addr = instr[24:20];
  assign rf.rd       = instr[11:7];
  assign rf.we       = ctrl.we;
  assign rf.wd       = alu_y;

  // srai takes its shift amount from imm[4:0], which is instr[24:20].
  assign alu_b = ctrl.use_imm ? imm : rf.rs2_data;

  alu u_alu (
    .op     (ctrl.op),
    .a      (rf.rs1_data),
    .b      (alu_b),
    .result (alu_y)
  );
endmodule

// File: tb/tb_cpu.sv
// Directed bench for cpu: loads a program through the hierarchy and checks
// PC and register state after each rising edge.
module tb_cpu;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] exp_regs [0:31];
  logic [31:0] prog [0:11];

  cpu dut (.clk_i(clk_i), .rst_i(rst_i));

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic load_program();
    prog[0]  = enc_i(12'd10,  5'd0, 3'b000, 5'd1);            // addi x1,x0,10
    prog[1]  = enc_i(12'hFF8, 5'd0, 3'b000, 5'd2);            // addi x2,x0,-8
    prog[2]  = enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3);   // add
    prog[3]  = enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd4);   // sub
    prog[4]  = enc_r(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd5);   // mul
    prog[5]  = enc_r(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd6);   // and
    prog[6]  = enc_r(7'b0000000, 5'd2, 5'd1, 3'b100, 5'd7);   // xor
    prog[7]  = enc_r(7'b0000000, 5'd1, 5'd1, 3'b001, 5'd8);   // sll x8,x1,x1
    prog[8]  = enc_i({7'b0100000, 5'd1}, 5'd2, 3'b101, 5'd9); // srai x9,x2,1
    prog[9]  = enc_i(12'd5,   5'd0, 3'b000, 5'd0);            // addi x0,x0,5
    prog[10] = enc_i({7'b0000000, 5'd1}, 5'd2, 3'b101, 5'd10); // srli: unsupported
    prog[11] = enc_r(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd11);  // or: unsupported
    for (int i = 0; i < 256; i++)
      dut.Instruction_Memory.memory[i] = (i < 12) ? prog[i] : 32'h0;
    for (int i = 0; i < 32; i++) exp_regs[i] = 32'h0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    step();
    step();
    checks++;
    if (dut.PC.pc_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_pc: got %h want %h", dut.PC.pc_o, 32'h0);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dut.Registers.register[i] !== 32'h0) begin
        failures++;
        $display("FAIL reset_x%0d: got %h want %h", i, dut.Registers.register[i], 32'h0);
      end
    end
    rst_i = 1'b1;
  endtask

  task automatic test_addi();
    step();
    checks++;
    if (dut.PC.pc_o !== 32'd4 || dut.Registers.register[1] !== 32'd10) begin
      failures++;
      $display("FAIL addi_x1: got pc=%h x1=%h want pc=%h x1=%h",
               dut.PC.pc_o, dut.Registers.register[1], 32'd4, 32'd10);
    end
    step();
    checks++;
    if (dut.PC.pc_o !== 32'd8 || dut.Registers.register[2] !== 32'hFFFF_FFF8) begin
      failures++;
      $display("FAIL addi_x2: got pc=%h x2=%h want pc=%h x2=%h",
               dut.PC.pc_o, dut.Registers.register[2], 32'd8, 32'hFFFF_FFF8);
    end
    exp_regs[1] = 32'd10;
    exp_regs[2] = 32'hFFFF_FFF8;
  endtask

  task automatic test_arith();
    logic [31:0] want [0:2];
    want[0] = 32'd2;
    want[1] = 32'd18;
    want[2] = 32'hFFFF_FFB0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dut.Registers.register[3+i] !== want[i]) begin
        failures++;
        $display("FAIL arith_x%0d: got %h want %h", 3+i, dut.Registers.register[3+i], want[i]);
      end
      exp_regs[3+i] = want[i];
    end
  endtask

  task automatic test_logic_shift();
    logic [31:0] want [0:2];
    want[0] = 32'd8;
    want[1] = 32'hFFFF_FFF2;
    want[2] = 32'd10240;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dut.Registers.register[6+i] !== want[i]) begin
        failures++;
        $display("FAIL logic_x%0d: got %h want %h", 6+i, dut.Registers.register[6+i], want[i]);
      end
      exp_regs[6+i] = want[i];
    end
    checks++;
    if (dut.PC.pc_o !== 32'd32) begin
      failures++;
      $display("FAIL logic_pc: got %h want %h", dut.PC.pc_o, 32'd32);
    end
  endtask

  task automatic test_srai_x0();
    step();
    checks++;
    if (dut.Registers.register[9] !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL srai_x9: got %h want %h", dut.Registers.register[9], 32'hFFFF_FFFC);
    end
    exp_regs[9] = 32'hFFFF_FFFC;
    step();
    checks++;
    if (dut.Registers.register[0] !== 32'h0) begin
      failures++;
      $display("FAIL x0_write: got %h want %h", dut.Registers.register[0], 32'h0);
    end
  endtask

  task automatic test_nop_tail();
    logic [31:0] exp_pc;
    exp_pc = 32'd40;
    for (int n = 0; n < 12; n++) begin
      step();
      exp_pc = exp_pc + 32'd4;
      checks++;
      if (dut.PC.pc_o !== exp_pc) begin
        failures++;
        $display("FAIL nop_pc step %0d: got %h want %h", n, dut.PC.pc_o, exp_pc);
      end
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dut.Registers.register[i] !== exp_regs[i]) begin
        failures++;
        $display("FAIL nop_x%0d: got %h want %h", i, dut.Registers.register[i], exp_regs[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    rst_i = 1'b0;
    step();
    checks++;
    if (dut.PC.pc_o !== 32'h0) begin
      failures++;
      $display("FAIL midreset_pc: got %h want %h", dut.PC.pc_o, 32'h0);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dut.Registers.register[i] !== 32'h0) begin
        failures++;
        $display("FAIL midreset_x%0d: got %h want %h", i, dut.Registers.register[i], 32'h0);
      end
    end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (dut.Instruction_Memory.memory[i] !== prog[i]) begin
        failures++;
        $display("FAIL midreset_mem%0d: got %h want %h", i, dut.Instruction_Memory.memory[i], prog[i]);
      end
    end
    rst_i = 1'b1;
    step();
    checks++;
    if (dut.PC.pc_o !== 32'd4 || dut.Registers.register[1] !== 32'd10
        || dut.Registers.register[2] !== 32'h0) begin
      failures++;
      $display("FAIL restart: got pc=%h x1=%h x2=%h want pc=%h x1=%h x2=%h",
               dut.PC.pc_o, dut.Registers.register[1], dut.Registers.register[2],
               32'd4, 32'd10, 32'h0);
    end
  endtask

  task automatic test_wrap();
    for (int n = 0; n < 254; n++) step();
    checks++;
    if (dut.PC.pc_o !== 32'd1020) begin
      failures++;
      $display("FAIL wrap_pc_1020: got %h want %h", dut.PC.pc_o, 32'd1020);
    end
    dut.Instruction_Memory.memory[0] = enc_i(12'd7, 5'd0, 3'b000, 5'd12); // addi x12,x0,7
    step();
    checks++;
    if (dut.PC.pc_o !== 32'd1024) begin
      failures++;
      $display("FAIL wrap_pc_1024: got %h want %h", dut.PC.pc_o, 32'd1024);
    end
    step();
    checks++;
    if (dut.Registers.register[12] !== 32'd7 || dut.PC.pc_o !== 32'd1028) begin
      failures++;
      $display("FAIL wrap_alias: got x12=%h pc=%h want x12=%h pc=%h",
               dut.Registers.register[12], dut.PC.pc_o, 32'd7, 32'd1028);
    end
  endtask

  initial begin
    load_program();
    test_reset();
    test_addi();
    test_arith();
    test_logic_shift();
    test_srai_x0();
    test_nop_tail();
    test_mid_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
